// File: rtl/display_mode_ctrl.sv
// Frame-synchronous screen-mode sequencer: title/play/line-clear flash/game-over overlays.
// Latency 2 clk edges from vsync fall to outputs; no backpressure, clear_req is a held level answered by clear_ack.
module display_mode_ctrl #(
  parameter int FLASH_FRAMES     = 8,
  parameter int FLASH_BLINKS     = 3,
  parameter int OVER_HOLD_FRAMES = 120,
  parameter int ROWS             = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vsync,
  input  logic            start,
  input  logic            over,
  input  logic            clear_req,
  input  logic [ROWS-1:0] clear_rows,
  output logic            clear_ack,
  output logic [1:0]      mode,
  output logic [1:0]      overlay_sel,
  output logic [ROWS-1:0] row_flash_mask,
  output logic            restart_ok,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2,
    OVER  = 2'd3
  } mode_t;

  localparam int P_LAST = 2 * FLASH_BLINKS * FLASH_FRAMES - 1;
  localparam int PW     = $clog2(P_LAST + 1);
  localparam int FW     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  mode_t           state;
  logic            vsync_q;
  logic            vsync_d;
  logic            frame_tick;
  logic [ROWS-1:0] rows_lat;
  logic [PW-1:0]   p;
  logic [FW-1:0]   f;
  logic [15:0]     h;
  logic [15:0]     h_inc;

  // vsync is sampled once before edge detection, giving the two-edge latency.
  assign frame_tick = vsync_d & ~vsync_q;
  assign h_inc      = (h == 16'hFFFF) ? h : h + 16'd1;
  assign mode       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q        <= 1'b1;
      vsync_d        <= 1'b1;
      state          <= TITLE;
      overlay_sel    <= 2'd1;
      row_flash_mask <= '0;
      rows_lat       <= '0;
      clear_ack      <= 1'b0;
      restart_ok     <= 1'b0;
      frame_cnt      <= 16'd0;
      p              <= '0;
      f              <= '0;
      h              <= 16'd0;
    end else begin
      vsync_q   <= vsync;
      vsync_d   <= vsync_q;
      clear_ack <= 1'b0;
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 16'd1;
        case (state)
          TITLE: begin
            if (start) begin
              state       <= PLAY;
              overlay_sel <= 2'd0;
            end
          end
          PLAY: begin
            if (over) begin
              state       <= OVER;
              overlay_sel <= 2'd2;
              h           <= 16'd0;
              restart_ok  <= 1'b0;
            end else if (clear_req && (|clear_rows)) begin
              state          <= FLASH;
              rows_lat       <= clear_rows;
              row_flash_mask <= clear_rows;
              p              <= '0;
              f              <= '0;
            end else if (clear_req) begin
              clear_ack <= 1'b1;
            end
          end
          FLASH: begin
            p <= p + PW'(1);
            if (over) begin
              state          <= OVER;
              overlay_sel    <= 2'd2;
              row_flash_mask <= '0;
              clear_ack      <= 1'b1;
              h              <= 16'd0;
              restart_ok     <= 1'b0;
            end else if (p == PW'(P_LAST)) begin
              state          <= PLAY;
              row_flash_mask <= '0;
              clear_ack      <= 1'b1;
            end else if (f == FW'(FLASH_FRAMES - 1)) begin
              // Latched rows are never zero, so a non-empty mask means "on".
              row_flash_mask <= (|row_flash_mask) ? '0 : rows_lat;
              f              <= '0;
            end else begin
              f <= f + FW'(1);
            end
          end
          OVER: begin
            if (restart_ok && !start) begin
              state       <= TITLE;
              overlay_sel <= 2'd1;
              h           <= 16'd0;
              restart_ok  <= 1'b0;
            end else begin
              h          <= h_inc;
              restart_ok <= (h_inc >= 16'(OVER_HOLD_FRAMES));
            end
          end
          default: begin
            state       <= TITLE;
            overlay_sel <= 2'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with short flash and hold parameters.
module tb_display_mode_ctrl;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        start;
  logic        over;
  logic        clear_req;
  logic [19:0] clear_rows;
  logic        clear_ack;
  logic [1:0]  mode;
  logic [1:0]  overlay_sel;
  logic [19:0] row_flash_mask;
  logic        restart_ok;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int errors  = 0;
  int ack_cnt = 0;

  display_mode_ctrl #(
    .FLASH_FRAMES(2),
    .FLASH_BLINKS(2),
    .OVER_HOLD_FRAMES(3),
    .ROWS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vsync(vsync),
    .start(start),
    .over(over),
    .clear_req(clear_req),
    .clear_rows(clear_rows),
    .clear_ack(clear_ack),
    .mode(mode),
    .overlay_sel(overlay_sel),
    .row_flash_mask(row_flash_mask),
    .restart_ok(restart_ok),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (clear_ack) ack_cnt++;

  // One ~50-cycle vsync frame; returns #1 after the edge where outputs update.
  task automatic tick();
    @(negedge clk) vsync = 1'b1;
    repeat (45) @(negedge clk);
    vsync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; start = 1'b0; over = 1'b0;
    clear_req = 1'b0; clear_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
    vectors++; if (overlay_sel !== 2'd1) begin errors++; $display("FAIL reset_overlay got %0d exp 1", overlay_sel); end
    vectors++; if (row_flash_mask !== 20'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", row_flash_mask); end
    vectors++; if (clear_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", clear_ack); end
    vectors++; if (restart_ok !== 1'b0) begin errors++; $display("FAIL reset_restart_ok got %b exp 0", restart_ok); end
    vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_title();
    repeat (3) tick();
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL title_mode got %0d exp 0", mode); end
    vectors++; if (overlay_sel !== 2'd1) begin errors++; $display("FAIL title_overlay got %0d exp 1", overlay_sel); end
    vectors++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL title_frame_cnt got %0d exp 3", frame_cnt); end
    start = 1'b1;
    @(negedge clk) vsync = 1'b1;
    repeat (45) @(negedge clk);
    vsync = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL start_latency_early got %0d exp 0", mode); end
    @(posedge clk);
    #1;
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL start_mode got %0d exp 1", mode); end
    vectors++; if (overlay_sel !== 2'd0) begin errors++; $display("FAIL start_overlay got %0d exp 0", overlay_sel); end
  endtask

  task automatic test_clear_empty();
    int a0;
    a0 = ack_cnt;
    clear_req = 1'b1; clear_rows = 20'h0;
    tick();
    vectors++; if (clear_ack !== 1'b1) begin errors++; $display("FAIL empty_ack got %b exp 1", clear_ack); end
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL empty_mode got %0d exp 1", mode); end
    clear_req = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL empty_ack_count got %0d exp 1", ack_cnt - a0); end
  endtask

  task automatic test_flash();
    logic [19:0] exp_seq [8];
    int a0;
    exp_seq = '{20'h3, 20'h3, 20'h0, 20'h0, 20'h3, 20'h3, 20'h0, 20'h0};
    a0 = ack_cnt;
    clear_req = 1'b1; clear_rows = 20'h00003;
    tick();
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL flash_entry_mode got %0d exp 2", mode); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      vectors++;
      if (row_flash_mask !== exp_seq[i]) begin
        errors++; $display("FAIL flash_mask_%0d got %h exp %h", i, row_flash_mask, exp_seq[i]);
      end
    end
    tick();
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL flash_done_mode got %0d exp 1", mode); end
    vectors++; if (row_flash_mask !== 20'h0) begin errors++; $display("FAIL flash_done_mask got %h exp 0", row_flash_mask); end
    vectors++; if (clear_ack !== 1'b1) begin errors++; $display("FAIL flash_done_ack got %b exp 1", clear_ack); end
    clear_req = 1'b0; clear_rows = '0;
    repeat (3) @(negedge clk);
    vectors++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL flash_ack_count got %0d exp 1", ack_cnt - a0); end
  endtask

  task automatic test_abort();
    int a0;
    a0 = ack_cnt;
    clear_req = 1'b1; clear_rows = 20'h80001;
    tick();
    repeat (3) tick();
    vectors++; if (row_flash_mask !== 20'h0) begin errors++; $display("FAIL abort_pre_mask got %h exp 0", row_flash_mask); end
    over = 1'b1;
    tick();
    vectors++; if (mode !== 2'd3) begin errors++; $display("FAIL abort_mode got %0d exp 3", mode); end
    vectors++; if (overlay_sel !== 2'd2) begin errors++; $display("FAIL abort_overlay got %0d exp 2", overlay_sel); end
    vectors++; if (row_flash_mask !== 20'h0) begin errors++; $display("FAIL abort_mask got %h exp 0", row_flash_mask); end
    vectors++; if (restart_ok !== 1'b0) begin errors++; $display("FAIL abort_restart_ok got %b exp 0", restart_ok); end
    clear_req = 1'b0; clear_rows = '0;
    repeat (3) @(negedge clk);
    vectors++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL abort_ack_count got %0d exp 1", ack_cnt - a0); end
  endtask

  task automatic test_over_hold();
    logic exp_ok [5];
    int a0;
    exp_ok = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    start = 1'b1; over = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (mode !== 2'd3 || restart_ok !== exp_ok[i]) begin
        errors++; $display("FAIL hold_tick_%0d got mode %0d ok %b exp mode 3 ok %b", i + 1, mode, restart_ok, exp_ok[i]);
      end
    end
    start = 1'b0;
    tick();
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL over_exit_mode got %0d exp 0", mode); end
    vectors++; if (restart_ok !== 1'b0) begin errors++; $display("FAIL over_exit_restart_ok got %b exp 0", restart_ok); end
    vectors++; if (overlay_sel !== 2'd1) begin errors++; $display("FAIL over_exit_overlay got %0d exp 1", overlay_sel); end
    a0 = ack_cnt;
    clear_req = 1'b1; clear_rows = 20'h00005;
    tick();
    repeat (3) @(negedge clk);
    vectors++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL title_clear_ignored acks %0d exp 0", ack_cnt - a0); end
    vectors++; if (row_flash_mask !== 20'h0 || mode !== 2'd0) begin
      errors++; $display("FAIL title_clear_state got mask %h mode %0d exp 0 0", row_flash_mask, mode);
    end
    clear_req = 1'b0; clear_rows = '0;
  endtask

  task automatic test_wrap();
    @(negedge clk) dut.frame_cnt = 16'hFFFF;
    tick();
    vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL frame_cnt_wrap got %0d exp 0", frame_cnt); end
    tick();
    vectors++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL frame_cnt_after_wrap got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_reset_mid_flash();
    int a0;
    start = 1'b1;
    tick();
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL rst_setup_play got %0d exp 1", mode); end
    clear_req = 1'b1; clear_rows = 20'h00003;
    tick();
    tick();
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL rst_setup_flash got %0d exp 2", mode); end
    a0 = ack_cnt;
    @(negedge clk) reset = 1'b1;
    #1;
    vectors++;
    if (mode !== 2'd0 || overlay_sel !== 2'd1 || row_flash_mask !== 20'h0 ||
        clear_ack !== 1'b0 || restart_ok !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_flash got mode %0d ov %0d mask %h ack %b ok %b fc %0d exp 0 1 0 0 0 0",
               mode, overlay_sel, row_flash_mask, clear_ack, restart_ok, frame_cnt);
    end
    clear_req = 1'b0; clear_rows = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL reset_no_ack got %0d exp 0", ack_cnt - a0); end
  endtask

  initial begin
    test_reset();
    test_title();
    test_clear_empty();
    test_flash();
    test_abort();
    test_over_hold();
    test_wrap();
    test_reset_mid_flash();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
